gen_sequencer: RTL
==================

# gen_sequencer

Run-sequencing controller for the debug AXI-Stream data generator. Latches a run configuration and issues one-cycle start pulses to the generator, a configured number of times with an idle gap between runs. It monitors the generator's output handshake to detect end-of-run, and accumulates beat, packet and elapsed-cycle statistics for throughput measurement. It sits between the debug register file and the generator, which it drives through `gen_start` and `gen_max_cycles`.

## Interface
- `CYC_W`, 32: width of beats-per-run, matching the generator's `max_cycles`.
- `WDOG`, 4096: stall watchdog, in cycles without a beat while in RUN.
- `clk`  in  1  — single clock.
- `resetn`  in  1  — reset; asynchronous, active-low.
- `cfg_start`  in  1  — pulse; start a sequence. Ignored while `busy`.
- `cfg_abort`  in  1  — pulse; abandon the sequence and return to IDLE.
- `cfg_runs`  in  16  — number of runs.
- `cfg_cycles`  in  CYC_W  — beats per run.
- `cfg_gap`  in  16  — idle cycles between runs.
- `gen_start`  out  1  — start pulse to the generator.
- `gen_max_cycles`  out  CYC_W  — latched `cfg_cycles`.
- `mon_tvalid`, `mon_tready`, `mon_tlast`  in  1 each  — tap on the generator's output stream.
- `busy`  out  1  — sequence in progress.
- `done`  out  1  — one-cycle pulse on completion, abort or error.
- `runs_done`  out  16  — completed runs.
- `beats_total`  out  48  — beats observed.
- `pkts_total`  out  32  — beats with `mon_tlast` set.
- `elapsed`  out  48  — sequence duration in cycles.
- `err`  out  3  — sticky error flags: {stall, stray, bad_cfg}.

## Operation
- Beat = `mon_tvalid & mon_tready`.
- States: IDLE, START, RUN, GAP.
- IDLE, on `cfg_start`:
  - Latch `cfg_runs`, `cfg_cycles` and `cfg_gap`.
  - Clear all stats counters and `err`.
  - If `cfg_runs==0`: `done` pulse, stay in IDLE.
  - If `cfg_cycles==0`: set bad_cfg, `done` pulse, stay in IDLE.
  - Otherwise go to START.
- START: `gen_start`=1 for exactly this one cycle; go to RUN. The run beat counter is reset to 0.
- RUN: count beats.
  - When the beat count reaches `cfg_cycles`, `runs_done`++.
  - If `runs_done` (new value) == `cfg_runs`: `done`, go to IDLE.
  - Else if `cfg_gap==0`: go straight to START.
  - Else go to GAP.
- GAP: wait `cfg_gap` cycles, then go to START.
- Watchdog: in RUN, `WDOG` consecutive cycles without a beat sets stall, pulses `done`, and goes to IDLE.
- A beat seen in IDLE, START or GAP sets stray. Stray beats are still counted in `beats_total`; the sequence continues.
- `cfg_abort` in any non-IDLE state: go to IDLE, pulse `done`, counters hold their values. Abort beats a simultaneous end-of-run: `runs_done` is not incremented.
- `cfg_start` coincident with `cfg_abort` in IDLE: abort wins, and the start is ignored.
- Counters wrap modulo their width; no saturation.
- `elapsed` increments every cycle while `busy`, i.e. from START of run 1 through the completion cycle, inclusive.

## Timing
- Reset values:
  - State IDLE.
  - `gen_start`=0, `busy`=0, `done`=0.
  - All counters 0, `err`=0.
  - `gen_max_cycles`=0.
- All outputs are registered.
- `gen_start` rises 1 cycle after the accepted `cfg_start`.
- `busy` rises with `gen_start` and falls in the same cycle that `done` pulses.
- `done` rises 1 cycle after the final counted beat.
- Run-to-run spacing: from the final beat of run k to `gen_start` of run k+1 is `cfg_gap`+1 cycles.
- Reset asserted mid-sequence clears everything immediately. No `done` pulse is produced.
- `gen_max_cycles` is stable from START through the end of the sequence.

## Structure
- Package `gen_seq_pkg`:
  - State enum (IDLE, START, RUN, GAP).
  - Error bit indices (ERR_BADCFG=0, ERR_STRAY=1, ERR_STALL=2).
  - Stats widths (48/32/16).
- Sub-module `gen_seq_stats`:
  - Beat, packet and elapsed counters, plus the stray detector.
  - Inputs: beat, tlast, busy, clear.
  - Keeps the FSM file small.

## Test plan
- runs=3, cycles=8, gap=5, tready always high, generator model attached:
  - `runs_done`=3, `beats_total`=24, `pkts_total`=6.
  - 3 `gen_start` pulses, spaced 8+5+1 cycles apart.
  - One `done`; `err`=0.
- runs=0: `done` 1 cycle after `cfg_start`, no `gen_start`, `busy` never high.
- cycles=0, runs=2: `err`=3'b001, `done` pulse, no `gen_start`.
- tready held low for 4096 cycles mid-run: `err`=3'b100, `done` pulse, state returns to IDLE, `runs_done` unchanged.
- `cfg_abort` during GAP of run 2 of 4: `done`, `runs_done`=2, no further `gen_start`. A second `cfg_start` accepted afterwards clears the stats.
- Inject one beat during GAP: `err`=3'b010, `beats_total` = expected + 1, sequence completes normally.

Source files
------------

// File: rtl/gen_seq_pkg.sv
// Shared definitions for the run-sequencing controller.
//   seq_state_t : sequencer FSM states
//   ERR_*       : bit positions inside the 3-bit sticky error vector
//   *_W         : widths of the statistics and configuration counters
package gen_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    RUN   = 2'd2,
    GAP   = 2'd3
  } seq_state_t;

  localparam int ERR_BADCFG = 0;
  localparam int ERR_STRAY  = 1;
  localparam int ERR_STALL  = 2;

  localparam int BEATS_W   = 48;
  localparam int ELAPSED_W = 48;
  localparam int PKTS_W    = 32;
  localparam int RUNS_W    = 16;
  localparam int GAP_W     = 16;

endpackage

// File: rtl/gen_seq_stats.sv
// Throughput statistics for the run sequencer.
//   clk, resetn  : clock, asynchronous active-low reset
//   clear        : zero all statistics and the stray flag (sequence accepted)
//   beat, tlast  : handshake on the monitored stream and its tlast
//   busy         : sequence in progress; elapsed counts these cycles
//   in_run       : sequencer is in RUN; beats outside RUN are stray
//   beats_total, pkts_total, elapsed : wrapping counters
//   stray        : sticky, a beat was seen outside RUN
module gen_seq_stats
  import gen_seq_pkg::*;
(
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 clear,
  input  logic                 beat,
  input  logic                 tlast,
  input  logic                 busy,
  input  logic                 in_run,
  output logic [BEATS_W-1:0]   beats_total,
  output logic [PKTS_W-1:0]    pkts_total,
  output logic [ELAPSED_W-1:0] elapsed,
  output logic                 stray
);

  // clear wins over a coincident beat: the new sequence starts from zero
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beats_total <= '0;
      pkts_total  <= '0;
      elapsed     <= '0;
      stray       <= 1'b0;
    end else if (clear) begin
      beats_total <= '0;
      pkts_total  <= '0;
      elapsed     <= '0;
      stray       <= 1'b0;
    end else begin
      beats_total <= beats_total + BEATS_W'(beat);
      pkts_total  <= pkts_total + PKTS_W'(beat & tlast);
      elapsed     <= elapsed + ELAPSED_W'(busy);
      stray       <= stray | (beat & ~in_run);
    end
  end

endmodule

// File: rtl/gen_sequencer.sv
// Run-sequencing controller for the debug AXI-Stream data generator.
// Latches a run configuration, pulses gen_start once per run with an idle
// gap between runs, detects end-of-run from the generator's output
// handshake and accumulates beat/packet/elapsed statistics.
//   cfg_start/cfg_abort       : control pulses from the register file
//   cfg_runs/cycles/gap       : run configuration, latched on start
//   gen_start/gen_max_cycles  : generator control
//   mon_tvalid/tready/tlast   : tap on the generator output stream
//   busy/done                 : sequence status, done is a 1-cycle pulse
//   runs_done, beats_total, pkts_total, elapsed : statistics
//   err                       : sticky {stall, stray, bad_cfg}
module gen_sequencer
  import gen_seq_pkg::*;
#(
  parameter int CYC_W = 32,
  parameter int WDOG  = 4096
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic [RUNS_W-1:0]    cfg_runs,
  input  logic [CYC_W-1:0]     cfg_cycles,
  input  logic [GAP_W-1:0]     cfg_gap,
  output logic                 gen_start,
  output logic [CYC_W-1:0]     gen_max_cycles,
  input  logic                 mon_tvalid,
  input  logic                 mon_tready,
  input  logic                 mon_tlast,
  output logic                 busy,
  output logic                 done,
  output logic [RUNS_W-1:0]    runs_done,
  output logic [BEATS_W-1:0]   beats_total,
  output logic [PKTS_W-1:0]    pkts_total,
  output logic [ELAPSED_W-1:0] elapsed,
  output logic [2:0]           err
);

  localparam int WD_W = $clog2(WDOG + 1);

  seq_state_t        state_q, state_d;
  logic [RUNS_W-1:0] runs_q, runs_d, runs_done_q, runs_done_d, runs_inc;
  logic [GAP_W-1:0]  gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic [CYC_W-1:0]  cycles_q, cycles_d, beat_cnt_q, beat_cnt_d, beat_inc;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic              gen_start_q, gen_start_d, busy_q, busy_d, done_q, done_d;
  logic              bad_cfg_q, bad_cfg_d, stall_q, stall_d;
  logic              beat, accept, stray;

  assign beat     = mon_tvalid & mon_tready;
  // abort in IDLE masks a coincident start
  assign accept   = (state_q == IDLE) & cfg_start & ~cfg_abort;
  assign beat_inc = beat_cnt_q + CYC_W'(1);
  assign runs_inc = runs_done_q + RUNS_W'(1);

  always_comb begin
    state_d     = state_q;
    runs_d      = runs_q;
    gap_d       = gap_q;
    cycles_d    = cycles_q;
    runs_done_d = runs_done_q;
    beat_cnt_d  = beat_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    bad_cfg_d   = bad_cfg_q;
    stall_d     = stall_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          runs_d      = cfg_runs;
          cycles_d    = cfg_cycles;
          gap_d       = cfg_gap;
          runs_done_d = '0;
          bad_cfg_d   = 1'b0;
          stall_d     = 1'b0;
          if (cfg_runs == '0) begin
            done_d = 1'b1;
          end else if (cfg_cycles == '0) begin
            bad_cfg_d = 1'b1;
            done_d    = 1'b1;
          end else begin
            state_d = START;
          end
        end
      end
      START: begin
        beat_cnt_d = '0;
        wd_cnt_d   = '0;
        state_d    = RUN;
      end
      RUN: begin
        if (beat) begin
          wd_cnt_d   = '0;
          beat_cnt_d = beat_inc;
          if (beat_inc == cycles_q) begin
            runs_done_d = runs_inc;
            if (runs_inc == runs_q) begin
              done_d  = 1'b1;
              state_d = IDLE;
            end else if (gap_q == '0) begin
              state_d = START;
            end else begin
              // GAP lasts gap_q cycles; the counter runs down to zero
              gap_cnt_d = gap_q - GAP_W'(1);
              state_d   = GAP;
            end
          end
        end else if (wd_cnt_q == WD_W'(WDOG - 1)) begin
          stall_d = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          wd_cnt_d = wd_cnt_q + WD_W'(1);
        end
      end
      GAP: begin
        if (gap_cnt_q == '0) state_d = START;
        else                 gap_cnt_d = gap_cnt_q - GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
    // abort overrides any end-of-run or watchdog outcome in the same cycle
    if ((state_q != IDLE) && cfg_abort) begin
      state_d     = IDLE;
      done_d      = 1'b1;
      runs_done_d = runs_done_q;
      stall_d     = stall_q;
    end
    gen_start_d = (state_d == START);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      runs_q      <= '0;
      gap_q       <= '0;
      cycles_q    <= '0;
      runs_done_q <= '0;
      beat_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      wd_cnt_q    <= '0;
      bad_cfg_q   <= 1'b0;
      stall_q     <= 1'b0;
      gen_start_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      runs_q      <= runs_d;
      gap_q       <= gap_d;
      cycles_q    <= cycles_d;
      runs_done_q <= runs_done_d;
      beat_cnt_q  <= beat_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      bad_cfg_q   <= bad_cfg_d;
      stall_q     <= stall_d;
      gen_start_q <= gen_start_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  gen_seq_stats u_stats (
    .clk         (clk),
    .resetn      (resetn),
    .clear       (accept),
    .beat        (beat),
    .tlast       (mon_tlast),
    .busy        (busy_q),
    .in_run      (state_q == RUN),
    .beats_total (beats_total),
    .pkts_total  (pkts_total),
    .elapsed     (elapsed),
    .stray       (stray)
  );

  assign gen_start      = gen_start_q;
  assign gen_max_cycles = cycles_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign runs_done      = runs_done_q;
  assign err            = {stall_q, stray, bad_cfg_q};

endmodule
